// File: rtl/fma_result_collector.sv
// rtl/fma_result_collector.sv - gathers out-of-order FMA cluster results and streams the matrix row-major
module fma_result_collector #(
  parameter int M_DIM = 3,
  parameter int N_DIM = 3,
  localparam int NUM_FMA = M_DIM * N_DIM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_in,
  input  logic                    start_in,
  input  logic [1:0]              rows_in,
  input  logic [1:0]              cols_in,
  input  logic [NUM_FMA-1:0]      ready_in,
  input  logic [NUM_FMA*32-1:0]   result_in,
  input  logic                    error_in,
  output logic                    busy_out,
  output logic                    out_valid_out,
  input  logic                    out_ready_in,
  output logic [31:0]             out_data_out,
  output logic [1:0]              out_row_out,
  output logic [1:0]              out_col_out,
  output logic                    out_last_out,
  output logic                    done_out,
  output logic                    overrun_err_out,
  output logic                    cfg_err_out,
  output logic                    fma_err_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN} state_t;

  localparam logic [1:0] M_LIM = 2'(M_DIM);
  localparam logic [1:0] N_LIM = 2'(N_DIM);

  state_t               state_q, state_d;
  logic [1:0]           rows_q, rows_d;
  logic [1:0]           cols_q, cols_d;
  logic [NUM_FMA-1:0]   bitmap_q, bitmap_d;
  logic [1:0]           row_q, row_d;
  logic [1:0]           col_q, col_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 cfg_q, cfg_d;
  logic                 fma_q, fma_d;
  logic [NUM_FMA-1:0]   cap;
  logic [NUM_FMA-1:0]   active;
  logic [31:0]          results_q [NUM_FMA];
  logic [3:0]           idx;
  logic                 in_drain;
  logic                 at_last;
  logic                 dims_ok;

  // Slots inside the latched rows x cols window are the ones we wait for and emit.
  always_comb begin
    active = '0;
    for (int r = 0; r < M_DIM; r++) begin
      for (int c = 0; c < N_DIM; c++) begin
        active[r*N_DIM+c] = (r < int'(rows_q)) && (c < int'(cols_q));
      end
    end
  end

  assign dims_ok  = (rows_in != 2'd0) && (rows_in <= M_LIM) &&
                    (cols_in != 2'd0) && (cols_in <= N_LIM);
  assign in_drain = (state_q == ST_DRAIN);
  assign at_last  = (row_q == rows_q - 2'd1) && (col_q == cols_q - 2'd1);
  assign idx      = {2'b00, row_q} * 4'(N_DIM) + {2'b00, col_q};

  // Next-state for the FSM, capture mask, drain cursor and sticky error flags.
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    bitmap_d = bitmap_q;
    row_d    = row_q;
    col_d    = col_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    cfg_d    = cfg_q;
    fma_d    = fma_q;
    cap      = '0;
    if (clear_in) begin
      state_d  = ST_IDLE;
      bitmap_d = '0;
      row_d    = 2'd0;
      col_d    = 2'd0;
      ovr_d    = 1'b0;
      cfg_d    = 1'b0;
      fma_d    = 1'b0;
    end else begin
      if (state_q != ST_IDLE && error_in) fma_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (ready_in != '0) ovr_d = 1'b1;
          if (start_in) begin
            if (dims_ok) begin
              rows_d   = rows_in;
              cols_d   = cols_in;
              bitmap_d = '0;
              row_d    = 2'd0;
              col_d    = 2'd0;
              state_d  = ST_COLLECT;
            end else begin
              cfg_d = 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          cap = ready_in & active & ~bitmap_q;
          if ((ready_in & ~cap) != '0) ovr_d = 1'b1;
          bitmap_d = bitmap_q | cap;
          if ((bitmap_d & active) == active) begin
            row_d   = 2'd0;
            col_d   = 2'd0;
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (ready_in != '0) ovr_d = 1'b1;
          if (out_ready_in) begin
            if (at_last) begin
              state_d  = ST_IDLE;
              bitmap_d = '0;
              done_d   = 1'b1;
            end else if (col_q == cols_q - 2'd1) begin
              col_d = 2'd0;
              row_d = row_q + 2'd1;
            end else begin
              col_d = col_q + 2'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rows_q   <= 2'd0;
      cols_q   <= 2'd0;
      bitmap_q <= '0;
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cfg_q    <= 1'b0;
      fma_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      bitmap_q <= bitmap_d;
      row_q    <= row_d;
      col_q    <= col_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      cfg_q    <= cfg_d;
      fma_q    <= fma_d;
    end
  end

  // Result matrix: a slot is written only on its first strobe in a collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_FMA; k++) results_q[k] <= 32'd0;
    end else begin
      for (int k = 0; k < NUM_FMA; k++) begin
        if (cap[k]) results_q[k] <= result_in[k*32 +: 32];
      end
    end
  end

  assign busy_out        = (state_q != ST_IDLE);
  assign out_valid_out   = in_drain;
  assign out_data_out    = in_drain ? results_q[idx] : 32'd0;
  assign out_row_out     = in_drain ? row_q : 2'd0;
  assign out_col_out     = in_drain ? col_q : 2'd0;
  assign out_last_out    = in_drain && at_last;
  assign done_out        = done_q;
  assign overrun_err_out = ovr_q;
  assign cfg_err_out     = cfg_q;
  assign fma_err_out     = fma_q;

endmodule

// File: tb/tb_fma_result_collector.sv
// tb/tb_fma_result_collector.sv - directed self-checking bench for fma_result_collector
module tb_fma_result_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear_in, start_in, error_in, out_ready_in;
  logic [1:0]   rows_in, cols_in;
  logic [8:0]   ready_in;
  logic [287:0] result_in;
  logic         busy_out, out_valid_out, out_last_out, done_out;
  logic         overrun_err_out, cfg_err_out, fma_err_out;
  logic [31:0]  out_data_out;
  logic [1:0]   out_row_out, out_col_out;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] fv [9];
  logic [31:0] exp_d [9];

  fma_result_collector dut (
    .clk(clk), .rst(rst), .clear_in(clear_in), .start_in(start_in),
    .rows_in(rows_in), .cols_in(cols_in), .ready_in(ready_in),
    .result_in(result_in), .error_in(error_in), .busy_out(busy_out),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .out_data_out(out_data_out), .out_row_out(out_row_out),
    .out_col_out(out_col_out), .out_last_out(out_last_out),
    .done_out(done_out), .overrun_err_out(overrun_err_out),
    .cfg_err_out(cfg_err_out), .fma_err_out(fma_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input int r, input int c, input logic l);
    chk({tag, "_valid"}, 32'(out_valid_out), 32'd1);
    chk({tag, "_data"}, out_data_out, d);
    chk({tag, "_row"}, 32'(out_row_out), 32'(r));
    chk({tag, "_col"}, 32'(out_col_out), 32'(c));
    chk({tag, "_last"}, 32'(out_last_out), 32'(l));
  endtask

  task automatic start(input logic [1:0] r, input logic [1:0] c);
    rows_in = r; cols_in = c; start_in = 1'b1;
    cyc();
    start_in = 1'b0;
  endtask

  initial begin
    int b, i;
    fv[0] = 32'h3F800000; fv[1] = 32'h40000000; fv[2] = 32'h40400000;
    fv[3] = 32'h40800000; fv[4] = 32'h40A00000; fv[5] = 32'h40C00000;
    fv[6] = 32'h40E00000; fv[7] = 32'h41000000; fv[8] = 32'h41100000;
    rst = 1'b1; clear_in = 1'b0; start_in = 1'b0; error_in = 1'b0;
    out_ready_in = 1'b0; rows_in = 2'd0; cols_in = 2'd0;
    ready_in = '0; result_in = '0;

    // reset state
    cyc();
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_valid", 32'(out_valid_out), 32'd0);
    chk("rst_data", out_data_out, 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_errs", {29'd0, overrun_err_out, cfg_err_out, fma_err_out}, 32'd0);
    rst = 1'b0;

    // 1) 3x3, all strobes in one cycle, values 1.0..9.0
    start(2'd3, 2'd3);
    chk("t1_busy", 32'(busy_out), 32'd1);
    chk("t1_novalid", 32'(out_valid_out), 32'd0);
    for (int k = 0; k < 9; k++) result_in[k*32 +: 32] = fv[k];
    ready_in = 9'h1FF;
    cyc();
    ready_in = '0; out_ready_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      beat("t1", fv[k], k / 3, k % 3, k == 8);
      chk("t1_nodone", 32'(done_out), 32'd0);
      cyc();
    end
    chk("t1_valid_off", 32'(out_valid_out), 32'd0);
    chk("t1_done", 32'(done_out), 32'd1);
    chk("t1_idle", 32'(busy_out), 32'd0);
    cyc();
    chk("t1_done_pulse", 32'(done_out), 32'd0);
    chk("t1_ovr", 32'(overrun_err_out), 32'd0);

    // 2) 3x3, strobes in reverse order one per cycle
    start(2'd3, 2'd3);
    for (int k = 0; k < 9; k++) result_in[k*32 +: 32] = 32'h10000000 + 32'(k);
    for (int k = 8; k >= 0; k--) begin
      ready_in = 9'(1 << k);
      cyc();
      chk("t2_busy", 32'(busy_out), 32'd1);
      chk("t2_valid", 32'(out_valid_out), (k == 0) ? 32'd1 : 32'd0);
    end
    ready_in = '0;
    for (int k = 0; k < 9; k++) begin
      beat("t2", 32'h10000000 + 32'(k), k / 3, k % 3, k == 8);
      cyc();
    end
    chk("t2_done", 32'(done_out), 32'd1);
    chk("t2_ovr", 32'(overrun_err_out), 32'd0);

    // 3) 2x2 with extra strobe on inactive slot 2
    start(2'd2, 2'd2);
    for (int k = 0; k < 9; k++) result_in[k*32 +: 32] = 32'h20000000 + 32'(k);
    ready_in = 9'b000000101;
    cyc();
    chk("t3_ovr", 32'(overrun_err_out), 32'd1);
    chk("t3_wait", 32'(out_valid_out), 32'd0);
    ready_in = 9'b000011010;
    cyc();
    ready_in = '0;
    beat("t3_b0", 32'h20000000, 0, 0, 1'b0); cyc();
    beat("t3_b1", 32'h20000001, 0, 1, 1'b0); cyc();
    beat("t3_b2", 32'h20000003, 1, 0, 1'b0); cyc();
    beat("t3_b3", 32'h20000004, 1, 1, 1'b1); cyc();
    chk("t3_done", 32'(done_out), 32'd1);
    chk("t3_valid_off", 32'(out_valid_out), 32'd0);

    // 4) duplicate strobe on slot 0, then stalled drain
    clear_in = 1'b1; cyc(); clear_in = 1'b0;
    chk("t4_clr_ovr", 32'(overrun_err_out), 32'd0);
    start(2'd3, 2'd3);
    for (int k = 0; k < 9; k++) begin
      result_in[k*32 +: 32] = 32'h30000000 + 32'(k);
      exp_d[k] = 32'h30000000 + 32'(k);
    end
    ready_in = 9'h001;
    cyc();
    chk("t4_ovr0", 32'(overrun_err_out), 32'd0);
    result_in[31:0] = 32'hDEADBEEF;
    ready_in = 9'h1FF;
    cyc();
    ready_in = '0;
    chk("t4_ovr1", 32'(overrun_err_out), 32'd1);
    b = 0; i = 0;
    while (b < 9 && i < 40) begin
      beat("t4", exp_d[b], b / 3, b % 3, b == 8);
      out_ready_in = (i % 3 == 0);
      cyc();
      if (out_ready_in) b++;
      i++;
    end
    chk("t4_complete", 32'(b), 32'd9);
    chk("t4_done", 32'(done_out), 32'd1);
    chk("t4_valid_off", 32'(out_valid_out), 32'd0);
    out_ready_in = 1'b1;

    // 5) bad config, clear mid-collect, reset mid-drain
    clear_in = 1'b1; cyc(); clear_in = 1'b0;
    start(2'd0, 2'd3);
    chk("t5_cfg_idle", 32'(busy_out), 32'd0);
    chk("t5_cfg_err", 32'(cfg_err_out), 32'd1);
    start(2'd3, 2'd3);
    chk("t5_busy", 32'(busy_out), 32'd1);
    error_in = 1'b1; ready_in = 9'h003;
    cyc();
    error_in = 1'b0; ready_in = '0;
    chk("t5_fma_err", 32'(fma_err_out), 32'd1);
    clear_in = 1'b1; cyc(); clear_in = 1'b0;
    chk("t5_clr_busy", 32'(busy_out), 32'd0);
    chk("t5_clr_errs", {29'd0, overrun_err_out, cfg_err_out, fma_err_out}, 32'd0);
    chk("t5_clr_valid", 32'(out_valid_out), 32'd0);
    chk("t5_clr_done", 32'(done_out), 32'd0);
    cyc();
    chk("t5_clr_nodone", 32'(done_out), 32'd0);

    start(2'd3, 2'd3);
    for (int k = 0; k < 9; k++) result_in[k*32 +: 32] = 32'h40000000 + 32'(k);
    ready_in = 9'h1FF; error_in = 1'b1;
    cyc();
    ready_in = '0; error_in = 1'b0; out_ready_in = 1'b0;
    beat("t5_drain", 32'h40000000, 0, 0, 1'b0);
    chk("t5_fma_pre", 32'(fma_err_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid_out), 32'd0);
    chk("t5_rst_busy", 32'(busy_out), 32'd0);
    chk("t5_rst_data", out_data_out, 32'd0);
    chk("t5_rst_last", 32'(out_last_out), 32'd0);
    chk("t5_rst_errs", {28'd0, done_out, overrun_err_out, cfg_err_out, fma_err_out}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
